// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
// Circular FIFO of free physical register IDs feeding the rename stage.
// Rename pops one ID per cycle at the head. Retirement pushes the old
// physical register (old_wb) back at the tail. At reset, IDs
// ARCH_REGS..PRF_SIZE-1 are free, and IDs 0..ARCH_REGS-1 are owned by the
// architectural map.
//
// Ports:
//   i_clk          clock, all state updates on posedge
//   i_rst          synchronous active-high reset
//   i_alloc_req    rename requests one free physical register this cycle
//   o_alloc_valid  a free ID is available (count != 0)
//   o_alloc_id     ID at head, meaningful only when o_alloc_valid=1
//   i_release_ena  retirement returns one ID this cycle
//   i_release_id   ID being freed
//   o_free_count   number of IDs currently held, 0..PRF_SIZE
//   o_empty        free count is zero
//   o_full         free count is PRF_SIZE
//   o_release_err  sticky: a release was dropped because the list was full
// -----------------------------------------------------------------------------
module free_list #(
    parameter int PRF_SIZE  = 16,
    parameter int ARCH_REGS = 8,
    parameter int ID_W      = $clog2(PRF_SIZE)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_alloc_req,
    output logic            o_alloc_valid,
    output logic [ID_W-1:0] o_alloc_id,
    input  logic            i_release_ena,
    input  logic [ID_W-1:0] i_release_id,
    output logic [ID_W:0]   o_free_count,
    output logic            o_empty,
    output logic            o_full,
    output logic            o_release_err
);

    localparam logic [ID_W:0]   CNT_ZERO  = (ID_W+1)'(0);
    localparam logic [ID_W:0]   CNT_ONE   = (ID_W+1)'(1);
    localparam logic [ID_W:0]   CNT_FULL  = (ID_W+1)'(PRF_SIZE);
    localparam logic [ID_W:0]   CNT_RESET = (ID_W+1)'(PRF_SIZE - ARCH_REGS);
    localparam logic [ID_W-1:0] PTR_ONE   = ID_W'(1);
    // Truncation to ID_W bits gives the mod-PRF_SIZE wrap for free.
    localparam logic [ID_W-1:0] TAIL_RESET = ID_W'(PRF_SIZE - ARCH_REGS);

    logic [ID_W-1:0] r_mem [PRF_SIZE];
    logic [ID_W-1:0] r_head;
    logic [ID_W-1:0] r_tail;
    logic [ID_W:0]   r_count;
    logic            r_release_err;

    logic            w_alloc_fire;
    logic            w_release_fire;
    logic            w_release_drop;
    logic [ID_W:0]   w_count_next;

    // Handshake decode: release may enter a full list only when an alloc frees a slot.
    always_comb begin
        w_alloc_fire   = 1'b0;
        w_release_fire = 1'b0;
        w_release_drop = 1'b0;
        w_alloc_fire   = i_alloc_req && o_alloc_valid;
        if (i_release_ena) begin
            w_release_fire = !o_full || w_alloc_fire;
            w_release_drop = o_full && !w_alloc_fire;
        end else begin
            w_release_fire = 1'b0;
            w_release_drop = 1'b0;
        end
    end

    // Next occupancy: push and pop in the same cycle cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({w_release_fire, w_alloc_fire})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // State registers: storage, pointers, occupancy and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PRF_SIZE; i++) begin
                if (i < PRF_SIZE - ARCH_REGS) begin
                    r_mem[i] <= ID_W'(ARCH_REGS + i);
                end else begin
                    r_mem[i] <= '0;
                end
            end
            r_head        <= '0;
            r_tail        <= TAIL_RESET;
            r_count       <= CNT_RESET;
            r_release_err <= 1'b0;
        end else begin
            if (w_alloc_fire) begin
                r_head <= r_head + PTR_ONE;
            end
            // When full with a simultaneous alloc, tail equals head. The
            // alloc_id read this cycle sees the pre-write value.
            if (w_release_fire) begin
                r_mem[r_tail] <= i_release_id;
                r_tail        <= r_tail + PTR_ONE;
            end
            if (w_release_drop) begin
                r_release_err <= 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    assign o_alloc_valid = (r_count != CNT_ZERO);
    assign o_alloc_id    = r_mem[r_head];
    assign o_free_count  = r_count;
    assign o_empty       = (r_count == CNT_ZERO);
    assign o_full        = (r_count == CNT_FULL);
    assign o_release_err = r_release_err;

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
// Directed bench for free_list (PRF_SIZE=16, ARCH_REGS=8). Inputs are driven
// 1 time unit after a rising edge. Outputs depend only on registered state,
// so they are sampled in the same quiet window before the next edge.
// -----------------------------------------------------------------------------
module tb_free_list;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_valid;
    logic [3:0] alloc_id;
    logic       release_ena;
    logic [3:0] release_id;
    logic [4:0] free_count;
    logic       empty;
    logic       full;
    logic       release_err;

    int checks;
    int failures;

    free_list #(.PRF_SIZE(16), .ARCH_REGS(8)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alloc_req   (alloc_req),
        .o_alloc_valid (alloc_valid),
        .o_alloc_id    (alloc_id),
        .i_release_ena (release_ena),
        .i_release_id  (release_id),
        .o_free_count  (free_count),
        .o_empty       (empty),
        .o_full        (full),
        .o_release_err (release_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, int'(alloc_valid), 1);
        chk({tag, "_id"},    int'(alloc_id),    8);
        chk({tag, "_count"}, int'(free_count),  8);
        chk({tag, "_empty"}, int'(empty),       0);
        chk({tag, "_full"},  int'(full),        0);
        chk({tag, "_err"},   int'(release_err), 0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        alloc_req   = 1'b0;
        release_ena = 1'b0;
        release_id  = 4'd0;

        // Reset, then idle one cycle.
        tick();
        rst = 1'b0;
        tick();
        chk_reset_state("reset");

        // Drain the 8 reset-free IDs in order 8..15.
        alloc_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_id", int'(alloc_id), 8 + k);
            tick();
        end
        chk("drained_empty", int'(empty), 1);
        chk("drained_valid", int'(alloc_valid), 0);
        chk("drained_count", int'(free_count), 0);
        // A 9th request while empty changes nothing.
        tick();
        chk("extra_req_count", int'(free_count), 0);
        chk("extra_req_empty", int'(empty), 1);

        // Empty with release and alloc together: no bypass.
        release_ena = 1'b1;
        release_id  = 4'd3;
        chk("nobypass_valid_pre", int'(alloc_valid), 0);
        tick();
        alloc_req   = 1'b0;
        release_ena = 1'b0;
        chk("nobypass_valid", int'(alloc_valid), 1);
        chk("nobypass_id",    int'(alloc_id),    3);
        chk("nobypass_count", int'(free_count),  1);

        // Release 12, 13, 14 alone, bringing the count to 4.
        release_ena = 1'b1;
        for (int k = 0; k < 3; k++) begin
            release_id = 4'(12 + k);
            tick();
        end
        release_ena = 1'b0;
        chk("prefill_count", int'(free_count), 4);

        // Ten cycles of simultaneous alloc and release, releasing 0..9.
        // Expected allocation order is 3,12,13,14 and then 0..5.
        alloc_req   = 1'b1;
        release_ena = 1'b1;
        for (int k = 0; k < 10; k++) begin
            release_id = 4'(k);
            chk("steady_id", int'(alloc_id), (k < 4) ? ((k == 0) ? 3 : 11 + k) : (k - 4));
            chk("steady_count", int'(free_count), 4);
            tick();
        end
        alloc_req   = 1'b0;
        release_ena = 1'b0;
        chk("steady_after_count", int'(free_count), 4);
        chk("steady_after_id",    int'(alloc_id),   6);

        // Fill to full with 12 more releases: 10..15, then 0..5.
        release_ena = 1'b1;
        for (int k = 0; k < 12; k++) begin
            release_id = 4'((10 + k) % 16);
            tick();
        end
        release_ena = 1'b0;
        chk("full_flag",  int'(full),        1);
        chk("full_count", int'(free_count),  16);
        chk("full_err",   int'(release_err), 0);
        chk("full_id",    int'(alloc_id),    6);

        // Release alone while full: the ID is dropped and the error flag sets.
        release_ena = 1'b1;
        release_id  = 4'd7;
        tick();
        release_ena = 1'b0;
        chk("drop_err",   int'(release_err), 1);
        chk("drop_count", int'(free_count),  16);
        chk("drop_id",    int'(alloc_id),    6);

        // Full with alloc and release together: both fire, and alloc sees the pre-write value.
        alloc_req   = 1'b1;
        release_ena = 1'b1;
        release_id  = 4'd9;
        chk("full_both_id_pre", int'(alloc_id), 6);
        tick();
        alloc_req   = 1'b0;
        release_ena = 1'b0;
        chk("full_both_count", int'(free_count),  16);
        chk("full_both_id",    int'(alloc_id),    7);
        chk("full_both_err",   int'(release_err), 1);

        // Reset mid-stream with alloc and release both asserted.
        alloc_req   = 1'b1;
        release_ena = 1'b1;
        release_id  = 4'd2;
        rst         = 1'b1;
        tick();
        rst         = 1'b0;
        alloc_req   = 1'b0;
        release_ena = 1'b0;
        chk_reset_state("midrst");
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        chk("midrst_next_id",    int'(alloc_id),   9);
        chk("midrst_next_count", int'(free_count), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
